// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port among three requesters
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          req_valid,
  input  logic [2:0]          req_we,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_wdata,
  output logic [2:0]          req_ready,
  output logic [2:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t              state;
  logic [1:0]          last_grant;
  logic [1:0]          owner;
  logic [15:0]         count;
  logic [15:0]         count_inc;
  logic [1:0]          winner;
  logic                any_req;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Scan starts just after the previous grant so every requester gets a turn.
  function automatic logic [1:0] rr_pick(input logic [1:0] lg, input logic [2:0] v);
    logic [1:0] o0, o1, o2;
    case (lg)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (v[o0])      return o0;
    else if (v[o1]) return o1;
    else            return o2;
  endfunction

  always_comb begin
    any_req   = |req_valid;
    winner    = rr_pick(last_grant, req_valid);
    count_inc = count + 16'd1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (winner)
      2'd0: begin
        sel_we    = req_we[0];
        sel_addr  = req_addr[0 +: ADDR_W];
        sel_wdata = req_wdata[0 +: DATA_W];
      end
      2'd1: begin
        sel_we    = req_we[1];
        sel_addr  = req_addr[ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[DATA_W +: DATA_W];
      end
      default: begin
        sel_we    = req_we[2];
        sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[2*DATA_W +: DATA_W];
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 2'd2;
      owner      <= 2'd0;
      count      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_valid  <= 1'b1;
            mem_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            req_ready  <= 3'b001 << winner;
            owner      <= winner;
            last_grant <= winner;
            count      <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the same cycle as the timeout takes priority.
          if (mem_ack) begin
            rsp_valid <= 3'b001 << owner;
            rsp_rdata <= mem_rdata;
            mem_valid <= 1'b0;
            state     <= IDLE;
          end else if (count_inc == TO_LIMIT) begin
            rsp_valid <= 3'b001 << owner;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            mem_valid <= 1'b0;
            count     <= count_inc;
            state     <= IDLE;
          end else begin
            count <= count_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_we;
  logic [95:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output logic [2:0] g);
    g = 3'b000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ready != 3'b000) begin
        g = req_ready;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [63:0] agg;
    agg = {1'b0, req_ready, rsp_valid, rsp_err, mem_valid, mem_we} | 64'(rsp_rdata)
          | 64'(mem_addr) | 64'(mem_wdata);
    check(tag, agg, 64'd0);
  endtask

  logic [2:0] g;
  logic       seen;
  int         n;
  logic [2:0] exp_order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    step();
    step();
    check_all_zero("in_reset_zero");
    reset = 1'b0;

    // 1: idle after reset
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | mem_valid | (|req_ready) | (|rsp_valid);
    end
    check("idle_no_activity", 64'(seen), 64'd0);
    check_all_zero("idle_zero");

    // 2: requester 1 read with ack 3 cycles after mem_valid
    req_valid = 3'b010;
    req_addr[32 +: 32] = 32'h100;
    step();
    check("t2_ready", 64'(req_ready), 64'b010);
    check("t2_mem_valid", 64'(mem_valid), 64'd1);
    check("t2_mem_addr", 64'(mem_addr), 64'h100);
    check("t2_mem_we", 64'(mem_we), 64'd0);
    req_valid = 3'b000;
    step();
    check("t2_ready_once", 64'(req_ready), 64'd0);
    check("t2_addr_hold", 64'({mem_valid, mem_addr}), 64'h1_0000_0100);
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    check("t2_rsp_valid", 64'(rsp_valid), 64'b010);
    check("t2_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    check("t2_rsp_err", 64'(rsp_err), 64'd0);
    check("t2_mem_valid_drop", 64'(mem_valid), 64'd0);
    step();
    check("t2_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("t2_rdata_hold", 64'(rsp_rdata), 64'hDEADBEEF);

    // 3: all requesters held high after reset, round-robin order
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      wait_ready(g);
      check($sformatf("t3_grant%0d", t), 64'(g), 64'(exp_order[t]));
      mem_ack   = 1'b1;
      mem_rdata = 32'h1000 + 32'(t);
      step();
      mem_ack = 1'b0;
      if (t == 5) req_valid = 3'b000;
      check($sformatf("t3_rsp%0d", t), 64'({rsp_valid, req_ready}), 64'({exp_order[t], 3'b000}));
    end

    // 4: requester 2 write
    req_valid = 3'b100;
    req_we    = 3'b100;
    req_addr[64 +: 32]  = 32'h4;
    req_wdata[64 +: 32] = 32'h55;
    wait_ready(g);
    req_valid = 3'b000;
    req_we    = 3'b000;
    check("t4_ready", 64'(g), 64'b100);
    check("t4_cmd", 64'({mem_valid, mem_we, mem_addr[7:0], mem_wdata}), {30'd0, 2'b11, 8'h04, 32'h55});
    step();
    step();
    check("t4_cmd_hold", 64'({mem_valid, mem_we, mem_addr[7:0], mem_wdata}), {30'd0, 2'b11, 8'h04, 32'h55});
    mem_ack   = 1'b1;
    mem_rdata = 32'h77;
    step();
    mem_ack = 1'b0;
    check("t4_rsp_valid", 64'(rsp_valid), 64'b100);
    check("t4_rsp_rdata", 64'(rsp_rdata), 64'h77);

    // 5: timeout after 8 BUSY cycles without ack
    req_valid = 3'b001;
    req_addr[0 +: 32] = 32'h40;
    wait_ready(g);
    req_valid = 3'b000;
    check("t5_ready", 64'(g), 64'b001);
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (rsp_valid != 3'b000) break;
      if (!mem_valid) seen = 1'b1;
    end
    check("t5_cycles", 64'(n), 64'd8);
    check("t5_mem_held", 64'(seen), 64'd0);
    check("t5_rsp", 64'({rsp_valid, rsp_err, mem_valid}), 64'({3'b001, 1'b1, 1'b0}));
    check("t5_rdata_zero", 64'(rsp_rdata), 64'd0);
    step();
    check("t5_err_pulse", 64'(rsp_err), 64'd0);
    req_valid = 3'b010;
    req_addr[32 +: 32] = 32'h88;
    wait_ready(g);
    req_valid = 3'b000;
    check("t5_next_ready", 64'(g), 64'b010);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234;
    step();
    mem_ack = 1'b0;
    check("t5_next_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({3'b010, 1'b0, 32'h1234}));

    // 6: reset two cycles into BUSY; last_grant returns to 2
    req_valid = 3'b010;
    req_addr[32 +: 32] = 32'h200;
    wait_ready(g);
    req_valid = 3'b000;
    check("t6_ready", 64'(g), 64'b010);
    step();
    step();
    reset = 1'b1;
    #1;
    check_all_zero("t6_async_reset");
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | (|rsp_valid) | mem_valid;
    end
    check("t6_no_rsp", 64'(seen), 64'd0);
    req_valid = 3'b110;
    wait_ready(g);
    req_valid = 3'b000;
    check("t6_first_winner", 64'(g), 64'b010);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t6_rsp", 64'(rsp_valid), 64'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
